dmem_line_responder: RTL and testbench
======================================

Name: dmem_line_responder

Overview:
- Off-chip data memory model; the responder end of the 256-bit line interface driven by the data-cache controller.
- Accepts one line read or line write per request and completes it after a fixed, parameterised latency.
- Signals completion with a one-cycle acknowledge.
- Sits between the CPU top level's mem_* outputs and the testbench, replacing the ad-hoc memory model.
- Keeps saturating read/write transaction counters for performance checks.

Parameters:
LATENCY, 10, clock edges from request capture to the acknowledge cycle; legal range 1..255
DEPTH, 512, number of 256-bit lines stored; power of two
ADDR_LSB, 5, byte-offset bits dropped from the address (32-byte lines)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset, asynchronous, active-low
mem_enable_i  input  1  request valid; held high by the initiator until mem_ack_o
mem_write_i  input  1  1 = line write, 0 = line read; sampled with the request
mem_addr_i  input  32  byte address of the line
mem_data_i  input  256  write line data
mem_ack_o  output  1  completion pulse, exactly one cycle per request
mem_data_o  output  256  read line data; valid in the ack cycle of a read
busy_o  output  1  high while a request is outstanding (WAIT or ACK state)
rd_cnt_o  output  16  completed reads, saturating at 16'hFFFF
wr_cnt_o  output  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, mem_ack_o=0, mem_data_o=0, busy_o=0, rd_cnt_o=0, wr_cnt_o=0, latency counter=0. Storage array is not cleared.
- Reset mid-operation aborts the request. A write that has not reached its ACK cycle is never committed.
- Line index = mem_addr_i[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB].
  - Lower ADDR_LSB bits are ignored.
  - Upper bits are ignored, so addresses alias modulo DEPTH lines.
- FSM has states IDLE, WAIT and ACK.
  - IDLE: mem_enable_i is sampled only here. If it is 1 at edge t0:
    - capture index, write flag and write data into internal registers;
    - load counter with LATENCY-1;
    - go to WAIT.
    If it is 0, stay in IDLE.
  - WAIT: counter decrements each edge. When counter==0, go to ACK at the next edge. So ACK is entered at edge t0+LATENCY.
  - ACK: mem_ack_o=1 for exactly this cycle.
    - Read: mem_data_o holds array[captured index], registered on the edge that enters ACK.
    - Write: array[captured index] <= captured data on the edge leaving ACK; rd/wr counter increments on the same edge.
    - Always returns to IDLE.
- Input changes after capture are ignored. Captured values alone define the transaction.
- mem_data_o holds its last read value until the next read's ACK. Writes do not change it.
- Back-to-back requests:
  - If mem_enable_i is still high in the IDLE cycle after ACK, a new request is captured.
  - Minimum spacing between captures is LATENCY+2 edges.
  - A new request is never captured in the ACK cycle itself.
- Read-after-write to the same line returns the newly written data, since the write commits before the next capture.
- Counters saturate: at 16'hFFFF further completions leave the value unchanged.
- busy_o = (state != IDLE), registered with the state.
- Simultaneous mem_enable_i deassertion by the initiator during WAIT does not cancel the request; the ack is still produced.

Test Plan:
- Reset then idle: rst_i low 3 cycles, enable=0 for 20 cycles -> mem_ack_o, busy_o, mem_data_o, rd_cnt_o and wr_cnt_o all stay 0.
- Write then read, LATENCY=10:
  - Write line 0x0000_0400 with data {8{32'hDEADBEEF}} -> ack exactly 10 edges after capture, one cycle wide.
  - Read of 0x0000_041C -> mem_data_o={8{32'hDEADBEEF}} in its ack cycle; wr_cnt_o=1, rd_cnt_o=1.
- Back-to-back with enable held high across ack: write 0x40 then read 0x40 -> second capture at the IDLE cycle after ack; read returns the written data; acks spaced LATENCY+2=12 cycles apart.
- Aliasing: write 0x0000_0020 with pattern A, read 0x0000_4020 (DEPTH=512) -> returns A.
- Reset mid-write: assert rst_i low 5 cycles after capturing a write of B to 0x80 -> no ack. A later read of 0x80 returns the prior contents, not B; counters read 0.
- Saturation: preload wr_cnt_o via 65 540 writes with LATENCY=1 -> wr_cnt_o=16'hFFFF and stays there; rd_cnt_o unaffected.

Source files
------------

// File: rtl/dmem_line_responder.sv
// Off-chip data memory model: responder end of the 256-bit line interface.
// Each request is captured in IDLE, waits LATENCY edges, then acks for one
// cycle. Reads return data in the ack cycle. Writes commit on the edge that
// leaves ACK. Saturating read/write completion counters are kept.
module dmem_line_responder #(
  parameter int unsigned LATENCY  = 10,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned ADDR_LSB = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic         mem_ack_o,
  output logic [255:0] mem_data_o,
  output logic         busy_o,
  output logic [15:0]  rd_cnt_o,
  output logic [15:0]  wr_cnt_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [255:0]       wdata_q, wdata_d;
  logic [255:0]       rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic [15:0]        rd_cnt_q, rd_cnt_d;
  logic [15:0]        wr_cnt_q, wr_cnt_d;

  logic [255:0]       mem_q [DEPTH];

  // Address bits outside the line index are intentionally ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_LSB+IDX_W], mem_addr_i[ADDR_LSB-1:0]};

  // Next-state logic: request capture, latency countdown, ack and completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_enable_i) begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
          idx_d   = mem_addr_i[ADDR_LSB +: IDX_W];
          wr_d    = mem_write_i;
          wdata_d = mem_data_i;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ACK;
          // Read data is registered on the edge entering ACK.
          if (!wr_q) rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (wr_q) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
          if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and datapath registers; reset aborts any outstanding request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Line storage: not reset; a write commits only on the edge leaving ACK.
  always_ff @(posedge clk_i) begin
    if (state_q == ACK && wr_q) mem_q[idx_q] <= wdata_q;
  end

  assign mem_ack_o  = (state_q == ACK);
  assign mem_data_o = rdata_q;
  assign busy_o     = busy_q;
  assign rd_cnt_o   = rd_cnt_q;
  assign wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Self-checking bench for dmem_line_responder: randomized requests checked
// against a line-array reference model with saturating counters.
module tb_dmem_line_responder;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         mem_enable_i = 1'b0;
  logic         mem_write_i = 1'b0;
  logic [31:0]  mem_addr_i = '0;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_o;
  logic [255:0] mem_data_o;
  logic         busy_o;
  logic [15:0]  rd_cnt_o;
  logic [15:0]  wr_cnt_o;

  dmem_line_responder #(.LATENCY(LAT), .DEPTH(DEPTH), .ADDR_LSB(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_enable_i(mem_enable_i),
    .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_ack_o(mem_ack_o), .mem_data_o(mem_data_o), .busy_o(busy_o),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: line contents, validity, last read value, counters.
  logic [255:0] mdl [DEPTH];
  bit           mv  [DEPTH];
  logic [255:0] exp_rd_data = '0;
  int           exp_rd = 0;
  int           exp_wr = 0;

  // Results of the last do_req.
  int           r_lat;
  logic [255:0] r_data;
  bit           r_one;
  bit           r_busy;
  int           r_ack_cyc;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic mdl_do(input bit wr, input logic [31:0] a, input logic [255:0] d);
    int l;
    l = line_of(a);
    if (wr) begin
      mdl[l] = d;
      mv[l]  = 1;
      exp_wr = (exp_wr < 65535) ? exp_wr + 1 : 65535;
    end else begin
      exp_rd_data = mdl[l];
      exp_rd = (exp_rd < 65535) ? exp_rd + 1 : 65535;
    end
  endtask

  // Drives one request from a negedge in IDLE; returns at the negedge after
  // the ack cycle with enable low. Inputs are scrambled after capture.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d);
    int  n;
    bit  seen;
    mem_enable_i = 1'b1;
    mem_write_i  = wr;
    mem_addr_i   = a;
    mem_data_i   = d;
    @(posedge clk_i);
    #1;
    mem_write_i = ~wr;
    mem_addr_i  = $urandom;
    mem_data_i  = rnd_line();
    n = 0; seen = 0; r_busy = 1;
    while (!seen && n < 300) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (busy_o !== 1'b1) r_busy = 0;
      if (mem_ack_o === 1'b1) seen = 1;
    end
    r_lat     = n;
    r_ack_cyc = cyc;
    r_data    = mem_data_o;
    mem_enable_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    r_one = (mem_ack_o === 1'b0) && (busy_o === 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    mem_enable_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({mem_ack_o, busy_o, mem_data_o, rd_cnt_o, wr_cnt_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: ack=%b busy=%b data=%h rd=%0d wr=%0d, required all zero",
                 i, mem_ack_o, busy_o, mem_data_o, rd_cnt_o, wr_cnt_o);
      end
    end
  endtask

  task automatic test_write_read();
    logic [255:0] d;
    d = {8{32'hDEADBEEF}};
    do_req(1'b1, 32'h0000_0400, d);
    mdl_do(1'b1, 32'h0000_0400, d);
    n_checks++;
    if (r_lat !== LAT || !r_one || !r_busy) begin
      n_fail++;
      $display("FAIL wr_latency: lat=%0d one_cycle=%0d busy=%0d, required lat=%0d one_cycle=1 busy=1", r_lat, r_one, r_busy, LAT);
    end
    n_checks++;
    if (r_data !== exp_rd_data) begin
      n_fail++;
      $display("FAIL wr_keeps_rdata: got %h, required %h", r_data, exp_rd_data);
    end
    do_req(1'b0, 32'h0000_041C, '0);
    mdl_do(1'b0, 32'h0000_041C, '0);
    n_checks++;
    if (r_lat !== LAT || !r_one) begin
      n_fail++;
      $display("FAIL rd_latency: lat=%0d one_cycle=%0d, required lat=%0d one_cycle=1", r_lat, r_one, LAT);
    end
    n_checks++;
    if (r_data !== d) begin
      n_fail++;
      $display("FAIL rd_data: got %h, required %h", r_data, d);
    end
    n_checks++;
    if (rd_cnt_o !== 16'(exp_rd) || wr_cnt_o !== 16'(exp_wr) || exp_rd != 1 || exp_wr != 1) begin
      n_fail++;
      $display("FAIL wr_rd_counts: rd=%0d wr=%0d, required rd=1 wr=1", rd_cnt_o, wr_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    int c1, c2, n;
    bit seen;
    d = rnd_line();
    mem_enable_i = 1'b1;
    mem_write_i  = 1'b1;
    mem_addr_i   = 32'h40;
    mem_data_i   = d;
    @(posedge clk_i);
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(posedge clk_i); n++; @(negedge clk_i);
      if (mem_ack_o === 1'b1) seen = 1;
    end
    c1 = cyc;
    mdl_do(1'b1, 32'h40, d);
    // Enable stays high through the ack cycle; switch to a read of the same line.
    mem_write_i = 1'b0;
    mem_addr_i  = 32'h40;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(posedge clk_i); n++; @(negedge clk_i);
      if (mem_ack_o === 1'b1) seen = 1;
    end
    c2 = cyc;
    mdl_do(1'b0, 32'h40, '0);
    n_checks++;
    if (c2 - c1 !== LAT + 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d cycles between acks, required %0d", c2 - c1, LAT + 2);
    end
    n_checks++;
    if (mem_data_o !== exp_rd_data) begin
      n_fail++;
      $display("FAIL b2b_raw_data: got %h, required %h", mem_data_o, exp_rd_data);
    end
    mem_enable_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (mem_ack_o !== 1'b0 || rd_cnt_o !== 16'(exp_rd) || wr_cnt_o !== 16'(exp_wr)) begin
      n_fail++;
      $display("FAIL b2b_after: ack=%b rd=%0d wr=%0d, required ack=0 rd=%0d wr=%0d", mem_ack_o, rd_cnt_o, wr_cnt_o, exp_rd, exp_wr);
    end
  endtask

  task automatic test_alias();
    logic [255:0] a_pat;
    a_pat = rnd_line();
    do_req(1'b1, 32'h0000_0020, a_pat);
    mdl_do(1'b1, 32'h0000_0020, a_pat);
    do_req(1'b0, 32'h0000_4020, '0);
    mdl_do(1'b0, 32'h0000_4020, '0);
    n_checks++;
    if (r_data !== a_pat || r_lat !== LAT) begin
      n_fail++;
      $display("FAIL alias_read: data=%h lat=%0d, required data=%h lat=%0d", r_data, r_lat, a_pat, LAT);
    end
  endtask

  task automatic test_random();
    int wq[$];
    for (int k = 0; k < 24; k++) begin
      bit wr;
      int l;
      logic [31:0] a;
      logic [255:0] d;
      wr = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
      if (wr) l = int'($urandom_range(0, 7)) * 37 + 200;
      else    l = wq[$urandom_range(0, wq.size() - 1)];
      a = ($urandom & 32'hFFFF_C01F) | (32'(l) << 5);
      d = rnd_line();
      if (wr) wq.push_back(l);
      do_req(wr, a, d);
      mdl_do(wr, a, d);
      n_checks++;
      if (r_lat !== LAT || !r_one || !r_busy) begin
        n_fail++;
        $display("FAIL rnd_timing op %0d: lat=%0d one=%0d busy=%0d, required lat=%0d one=1 busy=1", k, r_lat, r_one, r_busy, LAT);
      end
      n_checks++;
      if (r_data !== exp_rd_data) begin
        n_fail++;
        $display("FAIL rnd_data op %0d wr=%0d line=%0d: got %h, required %h", k, wr, l, r_data, exp_rd_data);
      end
      n_checks++;
      if (rd_cnt_o !== 16'(exp_rd) || wr_cnt_o !== 16'(exp_wr)) begin
        n_fail++;
        $display("FAIL rnd_counts op %0d: rd=%0d wr=%0d, required rd=%0d wr=%0d", k, rd_cnt_o, wr_cnt_o, exp_rd, exp_wr);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [255:0] c_pat, b_pat;
    bit saw_ack;
    c_pat = rnd_line();
    b_pat = ~c_pat;
    do_req(1'b1, 32'h80, c_pat);
    mdl_do(1'b1, 32'h80, c_pat);
    mem_enable_i = 1'b1;
    mem_write_i  = 1'b1;
    mem_addr_i   = 32'h80;
    mem_data_i   = b_pat;
    @(posedge clk_i);
    saw_ack = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (mem_ack_o === 1'b1) saw_ack = 1;
    end
    rst_i = 1'b0;
    mem_enable_i = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || rd_cnt_o !== 16'd0 || wr_cnt_o !== 16'd0 || mem_data_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b rd=%0d wr=%0d data=%h, required all zero", busy_o, rd_cnt_o, wr_cnt_o, mem_data_o);
    end
    repeat (5) begin
      @(negedge clk_i);
      if (mem_ack_o === 1'b1) saw_ack = 1;
    end
    rst_i = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_rd_data = '0;
    repeat (LAT + 4) begin
      @(negedge clk_i);
      if (mem_ack_o === 1'b1) saw_ack = 1;
    end
    n_checks++;
    if (saw_ack) begin
      n_fail++;
      $display("FAIL aborted_ack: ack seen=1, required 0");
    end
    n_checks++;
    if (rd_cnt_o !== 16'd0 || wr_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL counts_after_reset: rd=%0d wr=%0d, required 0 0", rd_cnt_o, wr_cnt_o);
    end
    do_req(1'b0, 32'h80, '0);
    mdl_do(1'b0, 32'h80, '0);
    n_checks++;
    if (r_data !== exp_rd_data || r_lat !== LAT) begin
      n_fail++;
      $display("FAIL no_commit: data=%h lat=%0d, required data=%h lat=%0d", r_data, r_lat, exp_rd_data, LAT);
    end
  endtask

  task automatic test_saturation();
    // Preload the write counter near its ceiling instead of tens of thousands of writes.
    force dut.wr_cnt_q = 16'hFFFC;
    #1;
    release dut.wr_cnt_q;
    exp_wr = 65532;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic [255:0] d;
      a = $urandom;
      d = rnd_line();
      do_req(1'b1, a, d);
      mdl_do(1'b1, a, d);
      n_checks++;
      if (wr_cnt_o !== 16'(exp_wr) || rd_cnt_o !== 16'(exp_rd)) begin
        n_fail++;
        $display("FAIL saturation step %0d: wr=%h rd=%0d, required wr=%h rd=%0d", k, wr_cnt_o, rd_cnt_o, 16'(exp_wr), exp_rd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      mv[i]  = 0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alias();
    test_random();
    test_reset_mid_write();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
